// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   XLEN          : address/data width used by fetch entries
//   NOP_INSTR     : canonical NOP (addi x0,x0,0) carried by fault entries
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one instruction-buffer entry {instr, pc, fault}
package rv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries between memory and decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empty the buffer; a push in the same cycle lands in the empty buffer
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty or flushing)
//   count      : current occupancy (0..DEPTH)
//   head       : head entry (contents undefined when empty)
//   empty      : occupancy is zero
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  wr_idx;
    logic           full;
    logic           do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && !empty && !flush;
    // A flush restarts both pointers at slot 0, so a coincident push goes there.
    assign wr_idx = flush ? '0 : wr_ptr;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Requests are only issued while a slot is free, so a regular push never meets a full buffer.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over a
// req/gnt/rvalid handshake, buffers {instr, pc, fault} and hands them to decode.
//   clk, reset      : clock, asynchronous active-low reset
//   imem_req/addr   : fetch request and word address (held until gnt)
//   imem_gnt        : request accepted this cycle
//   imem_rvalid/rdata : response for the single outstanding request
//   redirect_valid/pc : branch/jump redirect; flushes the buffer
//   id_valid/ready  : decode handshake on the buffer head
//   id_instr/pc/fault : head entry (zero while the buffer is empty)
module fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN       = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            id_fault
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    if (XLEN != rv_pkg::XLEN) begin : g_xlen_check
        $error("fetch_unit: XLEN must equal rv_pkg::XLEN");
    end

    fetch_state_t     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  req_pc;
    logic             discard;

    logic [CW-1:0]    count;
    fetch_entry_t     head;
    fetch_entry_t     push_data;
    logic             empty;
    logic             push;
    logic             pop;
    logic             granted;
    logic             misaligned;
    logic             in_flight_next;

    // Credit rule: only ask for a word when its response is guaranteed a slot.
    assign imem_req   = reset && (state == REQ) && (count < CW'(FIFO_DEPTH));
    assign imem_addr  = pc;
    assign granted    = imem_req && imem_gnt;
    assign misaligned = (redirect_pc[1:0] != 2'b00);

    // A request is still outstanding after this edge if it is granted now, or an
    // earlier one has not returned yet. A response arriving in the redirect cycle
    // itself is consumed by the flush, so nothing is left to discard afterwards.
    assign in_flight_next = granted ||
                            (((state == WAIT) || ((state == FAULT) && discard)) && !imem_rvalid);

    always_comb begin
        push      = 1'b0;
        push_data = '{instr: imem_rdata, pc: req_pc, fault: 1'b0};
        if (redirect_valid) begin
            push      = misaligned;
            push_data = '{instr: NOP_INSTR, pc: redirect_pc, fault: 1'b1};
        end else if ((state == WAIT) && imem_rvalid && !discard) begin
            push = 1'b1;
        end
    end

    assign pop      = id_valid && id_ready && !redirect_valid;
    assign id_valid = !empty;
    assign id_instr = empty ? '0 : head.instr;
    assign id_pc    = empty ? '0 : head.pc;
    assign id_fault = empty ? 1'b0 : head.fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= REQ;
            pc      <= RESET_PC;
            req_pc  <= '0;
            discard <= 1'b0;
        end else if (redirect_valid) begin
            pc      <= redirect_pc;
            discard <= in_flight_next;
            if (misaligned) begin
                state <= FAULT;
            end else if (in_flight_next) begin
                state <= WAIT;
            end else begin
                state <= REQ;
            end
        end else begin
            case (state)
                REQ: begin
                    if (granted) begin
                        req_pc <= pc;
                        pc     <= pc + XLEN'(4);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                        state   <= REQ;
                    end
                end
                FAULT: begin
                    // Leave the fault only on redirect; just retire a dropped response.
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head),
        .empty     (empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_fault;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_fault       (id_fault)
    );

    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // memory responder state
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int unsigned gnt_pct;
    int unsigned ready_pct;
    int unsigned lat_min;
    int unsigned lat_max;
    bit          last_gnt;
    logic [31:0] last_gnt_addr;
    int          gnt_count;

    // reference model: the program-order stream decode should see
    logic [31:0] exp_pc;
    logic [31:0] fault_pc;
    bit          fault_due;
    bit          faulted;
    int          pops;
    bit          hold_req;
    logic [31:0] hold_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc    = RESET_PC;
        fault_due = 1'b0;
        faulted   = 1'b0;
        hold_req  = 1'b0;
    endtask

    // One clock cycle; entered and left 1 time unit after a falling edge.
    task automatic step(input int rdy, input bit redir, input logic [31:0] rpc);
        bit          req_now;
        logic [31:0] addr_now;
        req_now  = imem_req;
        addr_now = imem_addr;
        imem_gnt       = req_now && !pend && ($urandom_range(99) < gnt_pct);
        imem_rvalid    = pend && (pend_cnt == 0);
        imem_rdata     = imem_rvalid ? mem_word(pend_addr) : $urandom;
        id_ready       = (rdy < 0) ? ($urandom_range(99) < ready_pct) : (rdy != 0);
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (reset) begin
            if (hold_req) begin
                chk("req_hold", {31'b0, req_now}, 32'd1);
                chk("addr_hold", addr_now, hold_addr);
            end
            if (faulted) begin
                chk("fault_noreq", {31'b0, req_now}, 32'd0);
            end
            if (id_valid && id_ready && !redir) begin
                pops++;
                if (fault_due) begin
                    chk("fault_pc", id_pc, fault_pc);
                    chk("fault_instr", id_instr, 32'h0000_0013);
                    chk("fault_flag", {31'b0, id_fault}, 32'd1);
                    fault_due = 1'b0;
                end else if (faulted) begin
                    chk("no_pop_in_fault", {31'b0, id_valid}, 32'd0);
                end else begin
                    chk("pop_pc", id_pc, exp_pc);
                    chk("pop_instr", id_instr, mem_word(exp_pc));
                    chk("pop_fault", {31'b0, id_fault}, 32'd0);
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        if (imem_rvalid) pend = 1'b0;
        else if (pend) pend_cnt--;
        last_gnt = imem_gnt;
        if (imem_gnt) begin
            pend          = 1'b1;
            pend_addr     = addr_now;
            pend_cnt      = int'($urandom_range(lat_max, lat_min)) - 1;
            last_gnt_addr = addr_now;
            gnt_count++;
        end
        hold_req  = reset && req_now && !imem_gnt && !redir;
        hold_addr = addr_now;
        if (reset && redir) begin
            if (rpc[1:0] != 2'b00) begin
                fault_due = 1'b1;
                faulted   = 1'b1;
                fault_pc  = rpc;
            end else begin
                fault_due = 1'b0;
                faulted   = 1'b0;
                exp_pc    = rpc;
            end
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        int          rnd_pops;
        int unsigned r;
        logic [31:0] tgt;

        n_vec = 0; n_err = 0; pops = 0; gnt_count = 0;
        pend = 1'b0; pend_addr = '0; pend_cnt = 0; last_gnt = 1'b0; last_gnt_addr = '0;
        gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        model_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // reset state
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_fault", {31'b0, id_fault}, 32'd0);

        // latency: gnt in cycle 0, rvalid in cycle 1, id_valid in cycle 2
        reset = 1'b1;
        #1;
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
        step(1, 1'b0, '0);
        chk("lat_c1_valid", {31'b0, id_valid}, 32'd0);
        step(1, 1'b0, '0);
        chk("lat_c2_valid", {31'b0, id_valid}, 32'd1);
        chk("lat_c2_pc", id_pc, RESET_PC);
        repeat (6) step(1, 1'b0, '0);
        chk("seq_pops", pops, 32'd3);

        // decode stalled: buffer fills, requests stop, one pop frees one request
        repeat (10) step(0, 1'b0, '0);
        chk("full_noreq", {31'b0, imem_req}, 32'd0);
        chk("full_valid", {31'b0, id_valid}, 32'd1);
        step(1, 1'b0, '0);
        chk("credit_req", {31'b0, imem_req}, 32'd1);
        gnt_count = 0;
        repeat (5) step(0, 1'b0, '0);
        chk("credit_one_gnt", gnt_count, 32'd1);
        chk("refull_noreq", {31'b0, imem_req}, 32'd0);

        // redirect while a response is in flight: stale word must not appear
        lat_min = 3; lat_max = 3;
        last_gnt = 1'b0;
        for (int i = 0; i < 20 && !last_gnt; i++) step(1, 1'b0, '0);
        chk("wait_reached", {31'b0, last_gnt}, 32'd1);
        step(1, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 20 && !id_valid; i++) step(0, 1'b0, '0);
        chk("redir_pc", id_pc, 32'h0000_0100);
        chk("redir_instr", id_instr, mem_word(32'h0000_0100));

        // misaligned redirect: single fault entry, no fetches until next redirect
        step(0, 1'b1, 32'h0000_0202);
        chk("mis_valid", {31'b0, id_valid}, 32'd1);
        chk("mis_fault", {31'b0, id_fault}, 32'd1);
        chk("mis_pc", id_pc, 32'h0000_0202);
        chk("mis_instr", id_instr, 32'h0000_0013);
        repeat (8) step(1, 1'b0, '0);
        chk("mis_drained", {31'b0, id_valid}, 32'd0);
        step(1, 1'b1, 32'h0000_0300);
        for (int i = 0; i < 20 && !imem_req; i++) step(0, 1'b0, '0);
        chk("after_fault_addr", imem_addr, 32'h0000_0300);

        // redirect coinciding with a pop and a push
        gnt_pct = 0;
        for (int i = 0; i < 20 && (id_valid || pend); i++) step(1, 1'b0, '0);
        chk("drained", {31'b0, id_valid}, 32'd0);
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        step(0, 1'b0, '0);
        step(0, 1'b0, '0);
        step(0, 1'b0, '0);
        chk("pp_valid_before", {31'b0, id_valid}, 32'd1);
        chk("pp_in_wait", {31'b0, imem_req}, 32'd0);
        step(1, 1'b1, 32'h0000_0400);
        chk("pp_flushed", {31'b0, id_valid}, 32'd0);

        // PC wrap at the top of the address space
        step(1, 1'b1, 32'hFFFF_FFFC);
        last_gnt = 1'b0;
        for (int i = 0; i < 20 && !last_gnt; i++) step(1, 1'b0, '0);
        chk("wrap_top_addr", last_gnt_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 20 && !imem_req; i++) step(1, 1'b0, '0);
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);

        // asynchronous reset while waiting for a response
        lat_min = 3; lat_max = 3;
        step(1, 1'b0, '0);
        chk("pre_rst_gnt", {31'b0, last_gnt}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'b0, id_valid}, 32'd0);
        chk("mid_rst_pc", id_pc, 32'd0);
        model_reset();
        step(0, 1'b0, '0);
        step(0, 1'b0, '0);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 30 && !id_valid; i++) step(0, 1'b0, '0);
        chk("post_rst_pc", id_pc, RESET_PC);
        chk("post_rst_instr", id_instr, mem_word(RESET_PC));

        // randomized traffic against the stream model
        gnt_pct = 70; ready_pct = 60; lat_min = 1; lat_max = 3;
        rnd_pops = pops;
        for (int i = 0; i < 1500; i++) begin
            r   = $urandom_range(99);
            tgt = {20'h0, $urandom_range(1023) * 4};
            if (r == 0) tgt[1:0] = 2'(1 + $urandom_range(2));
            step(-1, (r < 3), tgt);
        end
        chk("random_liveness", {31'b0, (pops - rnd_pops) > 100}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
